// File: rtl/ad_ip_jesd204_tpl_pn_checker.sv
// Self-synchronising PN7/PN15 monitor for looped-back TPL sample words.
// Optional error counter enabled by defining PN_CHECKER_ERR_CNT_EN.
module ad_ip_jesd204_tpl_pn_checker #(
  parameter int unsigned DATA_PATH_WIDTH      = 4,
  parameter int unsigned CONVERTER_RESOLUTION = 16,
  parameter int unsigned OOS_THRESHOLD        = 16
) (
  input  logic                                            clk,
  input  logic                                            resetn,
  input  logic                                            data_valid,
  input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] data,
  input  logic                                            pn_sel,
  input  logic                                            clr,
  output logic                                            pn_oos,
  output logic                                            pn_err,
  output logic [31:0]                                     err_cnt
);

  localparam int unsigned Cr = CONVERTER_RESOLUTION;
  localparam int unsigned W  = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;
  localparam logic [7:0] RunMax = 8'(OOS_THRESHOLD);

  typedef enum logic {StOos, StSync} state_e;

  state_e         state_q, state_d;
  logic [7:0]     run_q, run_d;
  logic           have_prev_q, have_prev_d;
  logic [W-1:0]   prev_q, prev_d;
  logic           pn_err_q, pn_err_d;
  logic           sel_q;

  logic [W-1:0]   seq;
  logic [W-1:0]   pred;
  logic           match;
  logic           sel_chg;
  logic [7:0]     run_inc;

  // Sample 0 is earliest in time, so it lands in the MSBs of the bit-serial view.
  for (genvar i = 0; i < DATA_PATH_WIDTH; i++) begin : g_reorder
    assign seq[W-1-i*Cr -: Cr] = data[i*Cr +: Cr];
  end

  // Extend the previous word by W bits of the selected recurrence; ext[MSB] is oldest.
  function automatic logic [W-1:0] predict(input logic [W-1:0] prev, input logic sel);
    logic [2*W-1:0] ext;
    ext = {prev, {W{1'b0}}};
    for (int j = W - 1; j >= 0; j--) begin
      ext[j] = sel ? (ext[j+15] ^ ext[j+14]) : (ext[j+7] ^ ext[j+6]);
    end
    return ext[W-1:0];
  endfunction

  assign pred    = predict(prev_q, pn_sel);
  // An all-zero word would predict itself, so it never counts as a match.
  assign match   = (seq == pred) && (seq != '0);
  assign sel_chg = (pn_sel != sel_q);
  assign run_inc = run_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    pn_err_d    = pn_err_q;

    if (sel_chg) begin
      state_d     = StOos;
      run_d       = '0;
      have_prev_d = 1'b0;
    end else if (data_valid) begin
      prev_d      = seq;
      have_prev_d = 1'b1;
      if (have_prev_q) begin
        case (state_q)
          StOos: begin
            if (match) begin
              if (run_inc == RunMax) begin
                state_d = StSync;
                run_d   = '0;
              end else begin
                run_d = run_inc;
              end
            end else begin
              run_d = '0;
            end
          end
          StSync: begin
            if (!match) begin
              pn_err_d = 1'b1;
              if (run_inc == RunMax) begin
                state_d = StOos;
                run_d   = '0;
              end else begin
                run_d = run_inc;
              end
            end else begin
              run_d = '0;
            end
          end
          default: begin
            state_d = StOos;
            run_d   = '0;
          end
        endcase
      end
    end

    if (clr) begin
      pn_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StOos;
      run_q       <= '0;
      have_prev_q <= 1'b0;
      prev_q      <= '0;
      pn_err_q    <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      have_prev_q <= have_prev_d;
      prev_q      <= prev_d;
      pn_err_q    <= pn_err_d;
      sel_q       <= pn_sel;
    end
  end

  assign pn_oos = (state_q == StOos);
  assign pn_err = pn_err_q;

`ifdef PN_CHECKER_ERR_CNT_EN
  logic [31:0] err_cnt_q, err_cnt_d;
  logic        cnt_inc;

  assign cnt_inc = !sel_chg && data_valid && have_prev_q && (state_q == StSync) && !match;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
    end else if (cnt_inc && (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
